// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter: state encoding
// and frame/counter sizing helpers.
package piso_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_SHIFT = 2'b01;
    localparam state_t ST_GAP   = 2'b10;

    function automatic int frame_len(input int width, input int parity_en);
        return width + ((parity_en != 32'sd0) ? 32'sd1 : 32'sd0);
    endfunction

    function automatic int cnt_width(input int width, input int parity_en);
        return $clog2(frame_len(width, parity_en) + 32'sd1);
    endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// Load handshake between a word producer and the serial transmitter.
interface piso_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;

    modport master (output load_valid, output load_data, input  load_ready);
    modport slave  (input  load_valid, input  load_data, output load_ready);
endinterface

// File: rtl/piso_shift_reg.sv
// Loadable shift register. The first bit of a loaded word is handed straight to
// the caller, so the register keeps only the bits still to be sent.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_first,
    output logic             o_sout
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_load_rem;
    logic [WIDTH-1:0] w_shifted;

    assign o_first    = (MSB_FIRST != 0) ? i_data[WIDTH-1] : i_data[0];
    assign o_sout     = (MSB_FIRST != 0) ? r_data[WIDTH-1] : r_data[0];
    assign w_load_rem = (MSB_FIRST != 0) ? {i_data[WIDTH-2:0], 1'b0}
                                         : {1'b0, i_data[WIDTH-1:1]};
    assign w_shifted  = (MSB_FIRST != 0) ? {r_data[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_data[WIDTH-1:1]};

    // Storage: capture the remainder of a new word, or advance by one bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= w_load_rem;
        end else if (i_shift_en) begin
            r_data <= w_shifted;
        end else begin
            r_data <= r_data;
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: shifts a word out one bit per clock with a
// frame strobe, optional trailing even-parity bit and a done pulse in the gap cycle.
module piso_serial_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    piso_serial_tx_if.slave         load_if,
    output logic                    sdata,
    output logic                    sframe,
    output logic                    done,
    output logic                    busy
);

    localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam int CNT_W     = cnt_width(WIDTH, PARITY_EN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_parity;
    logic             r_sdata;
    logic             r_sframe;
    logic             r_done;

    logic             w_ready_st;
    logic             w_accept;
    logic             w_shift_en;
    logic             w_last_is_par;
    logic             w_first;
    logic             w_sout;

    assign w_ready_st    = (r_state == ST_IDLE) || (r_state == ST_GAP);
    assign w_accept      = load_if.load_valid && w_ready_st;
    assign w_shift_en    = (r_state == ST_SHIFT) && (r_cnt != CNT_ZERO);
    assign w_last_is_par = (PARITY_EN != 0) && (r_cnt == CNT_ONE);

    assign load_if.load_ready = rst_n && w_ready_st;
    assign busy   = (r_state == ST_SHIFT);
    assign sdata  = r_sdata;
    assign sframe = r_sframe;
    assign done   = r_done;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_shift_en (w_shift_en),
        .i_data     (load_if.load_data),
        .o_first    (w_first),
        .o_sout     (w_sout)
    );

    // Frame sequencing: accept, count bits out (parity last), one gap cycle with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= CNT_ZERO;
            r_parity <= 1'b0;
            r_sdata  <= 1'b0;
            r_sframe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_accept) begin
                        r_state  <= ST_SHIFT;
                        r_cnt    <= CNT_LOAD;
                        r_parity <= even_parity(load_if.load_data);
                        r_sdata  <= w_first;
                        r_sframe <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= CNT_ZERO;
                        r_parity <= r_parity;
                        r_sdata  <= 1'b0;
                        r_sframe <= 1'b0;
                    end
                    r_done <= 1'b0;
                end
                ST_SHIFT: begin
                    if (r_cnt == CNT_ZERO) begin
                        r_state  <= ST_GAP;
                        r_cnt    <= CNT_ZERO;
                        r_sdata  <= 1'b0;
                        r_sframe <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_state  <= ST_SHIFT;
                        r_cnt    <= r_cnt - CNT_ONE;
                        r_sdata  <= w_last_is_par ? r_parity : w_sout;
                        r_sframe <= 1'b1;
                        r_done   <= 1'b0;
                    end
                    r_parity <= r_parity;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= CNT_ZERO;
                    r_parity <= 1'b0;
                    r_sdata  <= 1'b0;
                    r_sframe <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three configurations (MSB/LSB first, with parity) share
// one stimulus stream and are checked every cycle against a frame-level model.
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tb_valid;
    logic [7:0] tb_data;

    logic sd_a, sf_a, dn_a, bz_a;
    logic sd_b, sf_b, dn_b, bz_b;
    logic sd_c, sf_c, dn_c, bz_c;

    logic [2:0] d_sd, d_sf, d_dn, d_bz, d_rdy;
    logic [2:0] e_sd, e_sf, e_dn;

    logic [15:0] m_bits [3];
    int          m_left [3];
    logic [15:0] cap    [3];
    int          n_frames [3];
    int          n_done   [3];
    int          last_start [3];
    int          prev_start [3];
    int          done_cyc   [3];
    logic [2:0]  prev_sf;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int acc;

    always #5 clk = ~clk;

    piso_serial_tx_if #(.WIDTH(8)) if_a ();
    piso_serial_tx_if #(.WIDTH(8)) if_b ();
    piso_serial_tx_if #(.WIDTH(8)) if_c ();

    assign if_a.load_valid = tb_valid;
    assign if_a.load_data  = tb_data;
    assign if_b.load_valid = tb_valid;
    assign if_b.load_data  = tb_data;
    assign if_c.load_valid = tb_valid;
    assign if_c.load_data  = tb_data;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_if(if_a.slave),
        .sdata(sd_a), .sframe(sf_a), .done(dn_a), .busy(bz_a));
    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_if(if_b.slave),
        .sdata(sd_b), .sframe(sf_b), .done(dn_b), .busy(bz_b));
    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .load_if(if_c.slave),
        .sdata(sd_c), .sframe(sf_c), .done(dn_c), .busy(bz_c));

    assign d_sd  = {sd_c, sd_b, sd_a};
    assign d_sf  = {sf_c, sf_b, sf_a};
    assign d_dn  = {dn_c, dn_b, dn_a};
    assign d_bz  = {bz_c, bz_b, bz_a};
    assign d_rdy = {if_c.load_ready, if_b.load_ready, if_a.load_ready};

    function automatic int msb_of(input int c);
        return (c == 1) ? 0 : 1;
    endfunction

    function automatic int par_of(input int c);
        return (c == 2) ? 1 : 0;
    endfunction

    // Frame contents in transmit order, bit 0 first on the line.
    function automatic logic [15:0] build(input logic [7:0] w, input int c);
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[i] = (msb_of(c) != 0) ? w[7-i] : w[i];
        if (par_of(c) != 0) b[8] = ^w;
        return b;
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[ch%0d] cyc=%0d: got %0h, expected %0h", nm, c, cyc, act, exp);
        end
    endtask

    // Model: line is busy while frame bits remain; one gap cycle with done; accept when line free.
    initial begin
        e_sd = '0; e_sf = '0; e_dn = '0;
        for (int c = 0; c < 3; c++) begin m_bits[c] = '0; m_left[c] = 0; end
        forever begin
            @(posedge clk);
            cyc++;
            for (int c = 0; c < 3; c++) begin
                if (!rst_n) begin
                    e_sd[c] = 1'b0; e_sf[c] = 1'b0; e_dn[c] = 1'b0; m_left[c] = 0;
                end else if (e_sf[c]) begin
                    if (m_left[c] > 0) begin
                        e_sd[c] = m_bits[c][0];
                        m_bits[c] = m_bits[c] >> 1;
                        m_left[c]--;
                        e_dn[c] = 1'b0;
                    end else begin
                        e_sd[c] = 1'b0; e_sf[c] = 1'b0; e_dn[c] = 1'b1;
                    end
                end else if (tb_valid) begin
                    m_bits[c] = build(tb_data, c);
                    m_left[c] = 8 + par_of(c);
                    e_sd[c] = m_bits[c][0];
                    m_bits[c] = m_bits[c] >> 1;
                    m_left[c]--;
                    e_sf[c] = 1'b1;
                    e_dn[c] = 1'b0;
                end else begin
                    e_sd[c] = 1'b0; e_sf[c] = 1'b0; e_dn[c] = 1'b0;
                end
            end
            chk_en = 1'b1;
        end
    end

    // Per-cycle compare plus frame capture for the literal checks.
    initial begin
        prev_sf = '0;
        for (int c = 0; c < 3; c++) begin
            cap[c] = '0; n_frames[c] = 0; n_done[c] = 0;
            last_start[c] = 0; prev_start[c] = 0; done_cyc[c] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                for (int c = 0; c < 3; c++) begin
                    chk("sdata",  c, 32'(d_sd[c]),  32'(e_sd[c]));
                    chk("sframe", c, 32'(d_sf[c]),  32'(e_sf[c]));
                    chk("done",   c, 32'(d_dn[c]),  32'(e_dn[c]));
                    chk("busy",   c, 32'(d_bz[c]),  32'(e_sf[c]));
                    chk("ready",  c, 32'(d_rdy[c]), 32'(rst_n && !e_sf[c]));
                    if (d_sf[c] && !prev_sf[c]) begin
                        cap[c] = '0;
                        n_frames[c]++;
                        prev_start[c] = last_start[c];
                        last_start[c] = cyc;
                    end
                    if (d_sf[c]) cap[c] = {cap[c][14:0], d_sd[c]};
                    if (d_dn[c]) begin n_done[c]++; done_cyc[c] = cyc; end
                    prev_sf[c] = d_sf[c];
                end
            end
        end
    end

    task automatic send_one(input logic [7:0] w);
        @(negedge clk);
        tb_valid = 1'b1;
        tb_data  = w;
        acc      = cyc;
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    int fr0 [3];
    int dn0 [3];

    task automatic snap();
        for (int c = 0; c < 3; c++) begin fr0[c] = n_frames[c]; dn0[c] = n_done[c]; end
    endtask

    initial begin
        rst_n = 1'b0; tb_valid = 1'b0; tb_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: 8'hC1 in all three orders/parity modes.
        send_one(8'hC1);
        repeat (12) @(negedge clk);
        chk("capA_C1", 0, 32'(cap[0]), 32'h00C1);
        chk("capB_C1", 1, 32'(cap[1]), 32'h0083);
        chk("capC_C1", 2, 32'(cap[2]), 32'h0183);
        chk("doneA_lat", 0, 32'(done_cyc[0] - acc), 32'd9);
        chk("doneB_lat", 1, 32'(done_cyc[1] - acc), 32'd9);
        chk("doneC_lat", 2, 32'(done_cyc[2] - acc), 32'd10);

        send_one(8'hC3);
        repeat (12) @(negedge clk);
        chk("capA_C3", 0, 32'(cap[0]), 32'h00C3);
        chk("capC_C3", 2, 32'(cap[2]), 32'h0186);

        // Back-to-back frames with load_data changing mid-frame.
        snap();
        @(negedge clk);
        tb_valid = 1'b1; tb_data = 8'hA5;
        @(negedge clk);
        tb_data = 8'h5A;
        repeat (12) @(negedge clk);
        tb_data = 8'h3C;
        @(negedge clk);
        tb_valid = 1'b0;
        repeat (14) @(negedge clk);
        chk("capA_5A", 0, 32'(cap[0]), 32'h005A);
        chk("capB_5A", 1, 32'(cap[1]), 32'h005A);
        chk("capC_5A", 2, 32'(cap[2]), 32'h00B4);
        chk("periodA", 0, 32'(last_start[0] - prev_start[0]), 32'd9);
        chk("periodC", 2, 32'(last_start[2] - prev_start[2]), 32'd10);
        chk("framesA_b2b", 0, 32'(n_frames[0] - fr0[0]), 32'd2);

        // Reset on cycle 4 of a frame, then a clean frame of ones.
        snap();
        send_one(8'h3C);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_sframe", 0, 32'(d_sf[0]), 32'd0);
        chk("rst_sdata",  2, 32'(d_sd[2]), 32'd0);
        repeat (12) @(negedge clk);
        chk("rst_no_doneA", 0, 32'(n_done[0] - dn0[0]), 32'd0);
        chk("rst_no_doneC", 2, 32'(n_done[2] - dn0[2]), 32'd0);
        send_one(8'hFF);
        repeat (12) @(negedge clk);
        chk("capA_FF", 0, 32'(cap[0]), 32'h00FF);
        chk("capC_FF", 2, 32'(cap[2]), 32'h01FE);
        chk("doneA_FF", 0, 32'(n_done[0] - dn0[0]), 32'd1);

        // load_valid pulse during SHIFT must be ignored.
        snap();
        send_one(8'h12);
        repeat (2) @(negedge clk);
        tb_valid = 1'b1; tb_data = 8'hEE;
        @(negedge clk);
        tb_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("capA_12", 0, 32'(cap[0]), 32'h0012);
        chk("framesA_ign", 0, 32'(n_frames[0] - fr0[0]), 32'd1);
        chk("framesC_ign", 2, 32'(n_frames[2] - fr0[2]), 32'd1);

        // load_valid held across reset: accept on first edge after release.
        snap();
        @(negedge clk);
        rst_n = 1'b0; tb_valid = 1'b1; tb_data = 8'h81;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc = cyc;
        @(negedge clk);
        tb_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("capA_81", 0, 32'(cap[0]), 32'h0081);
        chk("framesA_rst", 0, 32'(n_frames[0] - fr0[0]), 32'd1);
        chk("doneA_rst_lat", 0, 32'(done_cyc[0] - acc), 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- Parallel-in/serial-out transmitter; the sending end of the team's D-flip-flop shift-register serial receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk.
- Drives a frame strobe so the receiver's flip-flop chain knows which cycles carry bits.
- Optional even-parity bit is appended after the data bits.

Parameters:
WIDTH, 8, data word width (>=2)
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = bit 0 first
PARITY_EN, 0, 1 = append one even-parity bit after the data bits

Ports:
clk  input  1  rising-edge clock, sole clock
rst_n  input  1  synchronous active-low reset
load_valid  input  1  load_data is valid this cycle
load_data  input  WIDTH  word to transmit
load_ready  output  1  block can accept a word this cycle
sdata  output  1  serial data bit (registered)
sframe  output  1  high on every cycle sdata carries a frame bit (registered)
done  output  1  one-cycle pulse after the last frame bit (registered)
busy  output  1  high while in SHIFT

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n). Sampled only on the rising clk edge.
- Reset values at the edge with rst_n=0: state=IDLE, shift register=0, bit counter=0, parity accumulator=0, sdata=0, sframe=0, done=0.
- load_ready is decoded from state (IDLE or GAP) and forced to 0 while rst_n=0.
- FRAME_LEN = WIDTH + PARITY_EN.
- IDLE: sframe=0, sdata=0, load_ready=1. The word is accepted on the edge where load_valid & load_ready. It is captured into the shift register, the counter is set to FRAME_LEN-1, and the state moves to SHIFT.
- SHIFT: sframe=1, busy=1, load_ready=0.
  - The first bit appears on sdata in the cycle immediately after acceptance (latency 1).
  - One bit per cycle in order: MSB_FIRST selects the order; the parity bit, if enabled, comes last.
  - Parity = XOR of all WIDTH data bits (even parity), computed from the captured word.
  - load_valid is ignored in SHIFT; load_data is never re-sampled mid-frame.
  - When the counter is 0, the next edge moves to GAP.
- GAP: exactly one cycle. sframe=0, sdata=0, done=1, load_ready=1.
  - If load_valid=1: accept and go to SHIFT (back-to-back frames, exactly one idle cycle between frames).
  - Otherwise go to IDLE.
- Frame period under continuous load_valid = FRAME_LEN + 1 cycles.
- Counter width = clog2(FRAME_LEN+1). It never wraps below 0.
- Reset mid-frame: the frame is abandoned at the reset edge. No done pulse. sframe=0 from the next cycle.
- load_valid held high across reset: the first accept occurs on the first edge after rst_n returns to 1, with state=IDLE.
- sdata, sframe and done come straight from flops (no combinational path from inputs), so the receiver chain samples glitch-free.

Decomposition:
- Shared package piso_pkg holds:
  - the state encoding typedef (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10)
  - the FRAME_LEN function
  - the counter-width function.
- One natural sub-module, piso_shift_reg: WIDTH-bit loadable shift register with load, shift_en, MSB_FIRST and serial-out. The FSM, counter and parity logic stay in the top.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1, PARITY_EN=0; load 8'hC1 in IDLE -> sdata 1,1,0,0,0,0,0,1 on cycles 1..8 with sframe=1; cycle 9 done=1, sframe=0; cycle 10 load_ready=1 in IDLE.
- MSB_FIRST=0, load 8'hC1 -> sdata 1,0,0,0,0,0,1,1; done on cycle 9.
- PARITY_EN=1, MSB_FIRST=1, load 8'hC1 (three ones) -> 8 data bits, then parity bit 1 on cycle 9; done on cycle 10. Load 8'hC3 -> parity bit 0.
- load_valid held high, words 8'hA5 then 8'h5A -> second frame's first bit on the cycle after GAP; period 9 cycles; load_data changes during SHIFT do not alter transmitted bits.
- rst_n driven 0 on cycle 4 of a frame -> next cycle sframe=0, sdata=0, done never pulses. After release, load 8'hFF -> a clean 8-bit frame of ones.
- load_valid pulsed during SHIFT -> ignored (load_ready=0); no extra frame transmitted.
